axim_wr_arbiter: RTL and testbench
==================================

Name: axim_wr_arbiter

Overview:
- Shares one downstream AXI4 write path (AW, W, B) between NUM_MASTERS upstream masters.
- AW requests are granted round-robin. The grant order is queued so that W beats are steered to the master whose AW was accepted.
- B responses are routed back using master-index bits prepended to the downstream awid.
- Sits between the per-tenant AXI4 masters and the shared memory controller port.

Parameters:
- NUM_MASTERS, 4, number of upstream masters (2..16).
- ID_W, 4, upstream AXI ID width.
- AWP_W, 68, width of the opaque AW payload. Field order is {addr, len, size, burst, lock, cache, prot, user, qos}, so qos occupies bits [3:0].
- WP_W, 73, width of the opaque W payload {data, strb, user}.
- ORDER_DEPTH, 8, depth of the W-order FIFO (power of 2, at least 2).
- IDX_W, $clog2(NUM_MASTERS), derived; must not be overridden.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_awid  in  NUM_MASTERS*ID_W  upstream AW IDs.
- s_awpayload  in  NUM_MASTERS*AWP_W  upstream AW payloads.
- s_awvalid  in  NUM_MASTERS  upstream AW valids.
- s_awready  out  NUM_MASTERS  upstream AW readies.
- s_wpayload  in  NUM_MASTERS*WP_W  upstream W payloads.
- s_wlast  in  NUM_MASTERS  upstream W last flags.
- s_wvalid  in  NUM_MASTERS  upstream W valids.
- s_wready  out  NUM_MASTERS  upstream W readies.
- s_bid  out  ID_W  B ID, shared by all masters.
- s_bresp  out  2  B response, shared by all masters.
- s_bvalid  out  NUM_MASTERS  per-master B valid.
- s_bready  in  NUM_MASTERS  per-master B ready.
- m_awid  out  IDX_W+ID_W  downstream AW ID = {grant index, upstream id}.
- m_awpayload  out  AWP_W  downstream AW payload.
- m_awvalid  out  1  downstream AW valid.
- m_awready  in  1  downstream AW ready.
- m_wpayload  out  WP_W  downstream W payload.
- m_wlast  out  1  downstream W last.
- m_wvalid  out  1  downstream W valid.
- m_wready  in  1  downstream W ready.
- m_bid  in  IDX_W+ID_W  downstream B ID.
- m_bresp  in  2  downstream B response.
- m_bvalid  in  1  downstream B valid.
- m_bready  out  1  downstream B ready.
- bad_bid  out  1  one-cycle pulse when a B response carries an out-of-range master index.

Behaviour:
- Reset values:
  - AW FSM in IDLE; round-robin pointer = 0; order FIFO empty.
  - All valid/ready outputs 0; m_awid and m_awpayload 0; bad_bid 0.
- AW FSM, IDLE state:
  - A grant is made when some s_awvalid is high AND the order FIFO is not full.
  - Winner g = first requester at or after the round-robin pointer, searching cyclically.
  - g, s_awid[g] and s_awpayload[g] are registered; next state is HOLD.
  - s_awready is all 0 while in IDLE.
- AW FSM, HOLD state:
  - m_awvalid = 1 with the registered AW fields.
  - s_awready[g] = m_awready; all other s_awready bits are 0.
  - On m_awvalid & m_awready: push g into the order FIFO, set pointer = (g+1) mod NUM_MASTERS, go to IDLE.
  - Throughput: one AW per 2 cycles. Latency from s_awvalid to m_awvalid is 1 cycle.
- AW stability: the registered payload stays stable while HOLD stalls. Upstream holds valid per AXI, so the captured copy is authoritative.
- No FIFO overflow: the FIFO count cannot rise during HOLD, so a push in HOLD never overflows.
- W path (combinational), with h = FIFO head:
  - m_wvalid = !empty & s_wvalid[h].
  - m_w* = s_w*[h].
  - s_wready[h] = !empty & m_wready; all other s_wready bits are 0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - When the FIFO is empty, all W traffic stalls (W never leads its AW downstream).
- Push/pop in the same cycle: the count is unchanged. A push into an empty FIFO becomes visible at the head the next cycle.
- B path (combinational), with i = m_bid[IDX_W+ID_W-1:ID_W]:
  - If i < NUM_MASTERS: s_bvalid[i] = m_bvalid; m_bready = s_bready[i]; s_bid = m_bid[ID_W-1:0]; s_bresp = m_bresp.
  - Otherwise: m_bready = 1 (the beat is sunk), all s_bvalid are 0, and bad_bid pulses on the handshake.
- Reset mid-operation: all state is cleared immediately. Downstream must be reset in the same domain; in-flight bursts are abandoned.

Optional Feature:
- Macro AXIM_WR_ARB_QOS_EN.
- When defined:
  - In IDLE, only requesters whose awqos (payload bits [3:0]) equals the maximum awqos among valid requesters are eligible.
  - Round-robin applies among the eligible requesters.
  - Ties resolve exactly as plain round-robin.
- When undefined: qos is ignored for arbitration and passed through unchanged.

Decomposition:
- Package axim_arb_pkg:
  - AXI resp encodings (OKAY/EXOKAY/SLVERR/DECERR).
  - AW FSM state enum {IDLE, HOLD}.
  - Functions aw_payload_w(addr_w, user_w) and w_payload_w(data_w, user_w).
  - Localparam QOS_LSB = 0.
  - Round-robin search function rr_pick(req, ptr).
- Sub-module axim_arb_order_fifo: synchronous FIFO of IDX_W-bit entries with ORDER_DEPTH entries; provides full, empty and head outputs.

Test Plan:
- Single master 1, awid=3, len=3 (4 beats), m_awready=1:
  - m_awvalid rises 1 cycle after s_awvalid; m_awid={1,3}.
  - 4 W beats are forwarded; then s_bvalid[1]=1 with s_bid=3 when m_bid={1,3}.
- Masters 0..3 all requesting continuously: grants occur in order 0,1,2,3,0 and W beats follow grant order exactly.
- Master 2 W arrives 5 cycles before its AW: s_wready[2] stays 0 until its AW handshake plus 1 cycle, then beats flow.
- Hold m_wready=0 with ORDER_DEPTH=8 and queue 8 AWs: a 9th s_awvalid is not granted until the first wlast pop.
- m_bid index 5 with NUM_MASTERS=4: m_bready=1, no s_bvalid, and bad_bid pulses for one cycle.
- QOS_EN, master 0 qos=2 and master 3 qos=9 requesting: master 3 is granted first. Assert areset mid-HOLD: m_awvalid=0 next edge and the FIFO is empty.

Source files
------------

// File: rtl/axim_arb_pkg.sv
// Shared types and helpers for the AXI4 write-path arbiter.
package axim_arb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int QOS_LSB = 0;
    localparam int QOS_W   = 4;

    typedef enum logic {IDLE, HOLD} aw_state_t;

    function automatic int aw_payload_w(input int addr_w, input int user_w);
        return addr_w + 8 + 3 + 2 + 1 + 4 + 3 + user_w + QOS_W;
    endfunction

    function automatic int w_payload_w(input int data_w, input int user_w);
        return data_w + data_w / 8 + user_w;
    endfunction

    // First set bit at or after ptr, wrapping; unused high req bits stay 0.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr);
        logic [3:0] idx;
        rr_pick = ptr;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/axim_arb_order_fifo.sv
// Grant-order FIFO: remembers which master owns each accepted AW.
module axim_arb_order_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = cnt == (PW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/axim_wr_arbiter.sv
// N:1 AXI4 write arbiter (AW round-robin, W in grant order, B by id prefix).
// Define AXIM_WR_ARB_QOS_EN to restrict arbitration to the highest awqos.
module axim_wr_arbiter
    import axim_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = 4,
    parameter int AWP_W       = 68,
    parameter int WP_W        = 73,
    parameter int ORDER_DEPTH = 8,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_MASTERS*ID_W-1:0]  s_awid,
    input  logic [NUM_MASTERS*AWP_W-1:0] s_awpayload,
    input  logic [NUM_MASTERS-1:0]       s_awvalid,
    output logic [NUM_MASTERS-1:0]       s_awready,
    input  logic [NUM_MASTERS*WP_W-1:0]  s_wpayload,
    input  logic [NUM_MASTERS-1:0]       s_wlast,
    input  logic [NUM_MASTERS-1:0]       s_wvalid,
    output logic [NUM_MASTERS-1:0]       s_wready,
    output logic [ID_W-1:0]              s_bid,
    output logic [1:0]                   s_bresp,
    output logic [NUM_MASTERS-1:0]       s_bvalid,
    input  logic [NUM_MASTERS-1:0]       s_bready,
    output logic [IDX_W+ID_W-1:0]        m_awid,
    output logic [AWP_W-1:0]             m_awpayload,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [WP_W-1:0]              m_wpayload,
    output logic                         m_wlast,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    input  logic [IDX_W+ID_W-1:0]        m_bid,
    input  logic [1:0]                   m_bresp,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    output logic                         bad_bid
);
    aw_state_t state;
    logic [IDX_W-1:0] ptr, gidx, pick, head, bidx;
    logic [NUM_MASTERS-1:0] elig;
    logic [15:0] req;
    logic [3:0]  pick4;
    logic full, empty, push, pop, bok;
    logic unused_pick;

    logic [ID_W-1:0]  awid_a [NUM_MASTERS];
    logic [AWP_W-1:0] awpl_a [NUM_MASTERS];
    logic [WP_W-1:0]  wpl_a  [NUM_MASTERS];

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
        assign awid_a[m] = s_awid[m*ID_W +: ID_W];
        assign awpl_a[m] = s_awpayload[m*AWP_W +: AWP_W];
        assign wpl_a[m]  = s_wpayload[m*WP_W +: WP_W];
    end

`ifdef AXIM_WR_ARB_QOS_EN
    logic [QOS_W-1:0] qmax;
    always_comb begin
        qmax = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            if (s_awvalid[m] && awpl_a[m][QOS_LSB +: QOS_W] > qmax)
                qmax = awpl_a[m][QOS_LSB +: QOS_W];
        elig = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            elig[m] = awpl_a[m][QOS_LSB +: QOS_W] == qmax;
    end
`else
    assign elig = '1;
`endif

    assign req         = 16'(s_awvalid & elig);
    assign pick4       = rr_pick(req, 4'(ptr));
    assign pick        = pick4[IDX_W-1:0];
    assign unused_pick = ^pick4;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            m_awid      <= '0;
            m_awpayload <= '0;
        end else begin
            unique case (state)
                IDLE: if (|s_awvalid && !full) begin
                    gidx        <= pick;
                    m_awid      <= {pick, awid_a[pick]};
                    m_awpayload <= awpl_a[pick];
                    state       <= HOLD;
                end
                HOLD: if (m_awready) begin
                    ptr   <= (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_awvalid = state == HOLD;
    assign push      = m_awvalid && m_awready;
    assign s_awready = push ? NUM_MASTERS'(1) << gidx : '0;

    axim_arb_order_fifo #(
        .W     (IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .pop   (pop),
        .din   (gidx),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // W never leads its AW: nothing moves until the owner is at the head.
    assign m_wvalid   = !empty && s_wvalid[head];
    assign m_wlast    = s_wlast[head];
    assign m_wpayload = wpl_a[head];
    assign s_wready   = (!empty && m_wready) ? NUM_MASTERS'(1) << head : '0;
    assign pop        = m_wvalid && m_wready && m_wlast;

    assign bidx     = m_bid[IDX_W+ID_W-1:ID_W];
    assign bok      = 32'(bidx) < 32'(NUM_MASTERS);
    assign s_bid    = m_bid[ID_W-1:0];
    assign s_bresp  = m_bresp;
    assign s_bvalid = (bok && m_bvalid) ? NUM_MASTERS'(1) << bidx : '0;
    assign m_bready = bok ? s_bready[bidx] : 1'b1;

    // Unroutable responses are sunk; flag each one for a cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) bad_bid <= 1'b0;
        else        bad_bid <= m_bvalid && !bok;
    end

endmodule

// File: tb/tb_axim_wr_arbiter.sv
// Bench for axim_wr_arbiter: directed scenarios then random traffic vs a queue model.
module tb_axim_wr_arbiter;
    import axim_arb_pkg::*;

    localparam int N     = 5;
    localparam int ID_W  = 4;
    localparam int IDX_W = 3;
    localparam int AWP_W = 68;
    localparam int WP_W  = 73;
    localparam int DEPTH = 8;
`ifdef AXIM_WR_ARB_QOS_EN
    localparam bit QOS = 1'b1;
`else
    localparam bit QOS = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset;
    logic [N*ID_W-1:0]  s_awid;
    logic [N*AWP_W-1:0] s_awpayload;
    logic [N-1:0]       s_awvalid, s_awready;
    logic [N*WP_W-1:0]  s_wpayload;
    logic [N-1:0]       s_wlast, s_wvalid, s_wready;
    logic [ID_W-1:0]    s_bid;
    logic [1:0]         s_bresp;
    logic [N-1:0]       s_bvalid, s_bready;
    logic [IDX_W+ID_W-1:0] m_awid;
    logic [AWP_W-1:0]   m_awpayload;
    logic               m_awvalid, m_awready;
    logic [WP_W-1:0]    m_wpayload;
    logic               m_wlast, m_wvalid, m_wready;
    logic [IDX_W+ID_W-1:0] m_bid;
    logic [1:0]         m_bresp;
    logic               m_bvalid, m_bready, bad_bid;

    int checks, errors;

    // Reference model state: pending grant, rr pointer, order queue.
    int ptr, cur;
    int q[$];
    bit busy, exp_bad;
    logic [ID_W-1:0]  cur_id;
    logic [AWP_W-1:0] cur_pl;

    axim_wr_arbiter #(
        .NUM_MASTERS (N),
        .ID_W        (ID_W),
        .AWP_W       (AWP_W),
        .WP_W        (WP_W),
        .ORDER_DEPTH (DEPTH)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_awid      (s_awid),
        .s_awpayload (s_awpayload),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wpayload  (s_wpayload),
        .s_wlast     (s_wlast),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bid       (s_bid),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .m_awid      (m_awid),
        .m_awpayload (m_awpayload),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wpayload  (m_wpayload),
        .m_wlast     (m_wlast),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bid       (m_bid),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .bad_bid     (bad_bid)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [3:0] qos_of(input int m);
        logic [AWP_W-1:0] p;
        p = s_awpayload[m*AWP_W +: AWP_W];
        return p[QOS_LSB +: 4];
    endfunction

    function automatic int winner();
        logic [3:0] qmax;
        int m;
        qmax = '0;
        for (int k = 0; k < N; k++)
            if (s_awvalid[k] && qos_of(k) > qmax) qmax = qos_of(k);
        for (int k = 0; k < N; k++) begin
            m = (ptr + k) % N;
            if (s_awvalid[m] && (!QOS || qos_of(m) == qmax)) return m;
        end
        return -1;
    endfunction

    task automatic mreset();
        ptr = 0; cur = 0; busy = 0; exp_bad = 0;
        cur_id = '0; cur_pl = '0;
        q.delete();
    endtask

    task automatic update();
        int sz, h, w;
        if (areset) begin
            mreset();
            return;
        end
        exp_bad = m_bvalid && (int'(m_bid >> ID_W) >= N);
        sz = q.size();
        if (sz > 0) begin
            h = q[0];
            if (s_wvalid[h] && m_wready && s_wlast[h]) void'(q.pop_front());
        end
        if (busy) begin
            if (m_awready) begin
                q.push_back(cur);
                ptr  = (cur + 1) % N;
                busy = 0;
            end
        end else begin
            w = winner();
            if (w >= 0 && sz < DEPTH) begin
                busy   = 1;
                cur    = w;
                cur_id = s_awid[w*ID_W +: ID_W];
                cur_pl = s_awpayload[w*AWP_W +: AWP_W];
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] e;
        int h, bi;
        chk("awvalid", 128'(m_awvalid), 128'(busy));
        e = '0;
        if (busy && m_awready) e[cur] = 1'b1;
        chk("awready", 128'(s_awready), 128'(e));
        if (busy) begin
            chk("awid", 128'(m_awid), 128'({IDX_W'(cur), cur_id}));
            chk("awpayload", 128'(m_awpayload), 128'(cur_pl));
        end
        e = '0;
        if (q.size() > 0) begin
            h = q[0];
            if (m_wready) e[h] = 1'b1;
            chk("wvalid", 128'(m_wvalid), 128'(s_wvalid[h]));
            if (s_wvalid[h]) begin
                chk("wpayload", 128'(m_wpayload), 128'(s_wpayload[h*WP_W +: WP_W]));
                chk("wlast", 128'(m_wlast), 128'(s_wlast[h]));
            end
        end else begin
            chk("wvalid", 128'(m_wvalid), 128'(0));
        end
        chk("wready", 128'(s_wready), 128'(e));
        bi = int'(m_bid >> ID_W);
        e = '0;
        if (bi < N) begin
            if (m_bvalid) e[bi] = 1'b1;
            chk("bready", 128'(m_bready), 128'(s_bready[bi]));
            chk("bid", 128'(s_bid), 128'(m_bid[ID_W-1:0]));
            chk("bresp", 128'(s_bresp), 128'(m_bresp));
        end else begin
            chk("bready_sink", 128'(m_bready), 128'(1));
        end
        chk("bvalid", 128'(s_bvalid), 128'(e));
        chk("bad_bid", 128'(bad_bid), 128'(exp_bad));
    endtask

    task automatic step();
        @(negedge aclk);
        compare();
        @(posedge aclk);
        update();
        #1;
    endtask

    task automatic idle_inputs();
        s_awid = '0; s_awpayload = '0; s_awvalid = '0;
        s_wpayload = '0; s_wlast = '0; s_wvalid = '0;
        s_bready = '0; m_awready = 1'b0; m_wready = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        areset = 1'b1;
        mreset();
        step();
        step();
        areset = 1'b0;
    endtask

    int grants[$];
    int wq[$];
    int hs;

    initial begin
        checks = 0; errors = 0;
        idle_inputs();
        areset = 1'b1;
        mreset();
        #2;
        chk("rst_awvalid", 128'(m_awvalid), 128'(0));
        chk("rst_awready", 128'(s_awready), 128'(0));
        chk("rst_awid", 128'(m_awid), 128'(0));
        chk("rst_awpayload", 128'(m_awpayload), 128'(0));
        chk("rst_wvalid", 128'(m_wvalid), 128'(0));
        chk("rst_wready", 128'(s_wready), 128'(0));
        chk("rst_bvalid", 128'(s_bvalid), 128'(0));
        chk("rst_bready", 128'(m_bready), 128'(0));
        chk("rst_bad_bid", 128'(bad_bid), 128'(0));

        // Single master 1, awid 3, len 3.
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1; s_bready = '1;
        s_awid[1*ID_W +: ID_W] = 4'd3;
        s_awpayload[1*AWP_W +: AWP_W] = 68'(3) << 28;
        s_awvalid[1] = 1'b1;
        #1;
        chk("t1_awvalid_pre", 128'(m_awvalid), 128'(0));
        step();
        chk("t1_awvalid", 128'(m_awvalid), 128'(1));
        chk("t1_awid", 128'(m_awid), 128'(7'h13));
        chk("t1_awpayload", 128'(m_awpayload), 128'(68'(3) << 28));
        chk("t1_awready", 128'(s_awready), 128'(5'b00010));
        step();
        s_awvalid = '0;
        for (int b = 0; b < 4; b++) begin
            s_wpayload[1*WP_W +: WP_W] = 73'(100 + b);
            s_wlast[1] = (b == 3);
            s_wvalid[1] = 1'b1;
            #1;
            chk("t1_beat_valid", 128'(m_wvalid), 128'(1));
            chk("t1_beat_data", 128'(m_wpayload), 128'(100 + b));
            chk("t1_beat_ready", 128'(s_wready), 128'(5'b00010));
            step();
        end
        s_wvalid = '0; s_wlast = '0;
        #1;
        chk("t1_w_drained", 128'(m_wvalid), 128'(0));
        m_bid = 7'h13; m_bresp = RESP_EXOKAY; m_bvalid = 1'b1;
        #1;
        chk("t1_bvalid", 128'(s_bvalid), 128'(5'b00010));
        chk("t1_bid", 128'(s_bid), 128'(3));
        chk("t1_bresp", 128'(s_bresp), 128'(RESP_EXOKAY));
        step();
        m_bvalid = 1'b0;

        // Masters 0..3 requesting continuously.
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            s_awid[m*ID_W +: ID_W] = ID_W'(m);
            s_wpayload[m*WP_W +: WP_W] = WP_W'(m);
            s_wlast[m] = 1'b1; s_wvalid[m] = 1'b1; s_awvalid[m] = 1'b1;
        end
        grants.delete(); wq.delete();
        repeat (14) begin
            step();
            if (m_awvalid && m_awready) grants.push_back(int'(m_awid >> ID_W));
            if (m_wvalid && m_wready) wq.push_back(int'(m_wpayload[7:0]));
        end
        chk("t2_ngrants", 128'(grants.size() >= 5), 128'(1));
        chk("t2_nbeats", 128'(wq.size() >= 4), 128'(1));
        for (int k = 0; k < 5; k++)
            chk("t2_rr_order", 128'(grants[k]), 128'(k % 4));
        for (int k = 0; k < 4; k++)
            chk("t2_w_order", 128'(wq[k]), 128'(k));

        // Master 2 W arrives well before its AW.
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid[2] = 1'b1; s_wlast[2] = 1'b1;
        s_wpayload[2*WP_W +: WP_W] = 73'h1_2345;
        repeat (5) begin
            #1;
            chk("t3_wready_early", 128'(s_wready[2]), 128'(0));
            step();
        end
        s_awid[2*ID_W +: ID_W] = 4'd5;
        s_awvalid[2] = 1'b1;
        step();
        chk("t3_wready_hold", 128'(s_wready[2]), 128'(0));
        step();
        s_awvalid = '0;
        chk("t3_wready_go", 128'(s_wready[2]), 128'(1));
        chk("t3_wvalid_go", 128'(m_wvalid), 128'(1));
        step();
        s_wvalid = '0; s_wlast = '0;

        // Order FIFO fills while W is blocked.
        do_reset();
        m_awready = 1'b1;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_wlast[0] = 1'b1;
        hs = 0;
        repeat (24) begin
            step();
            if (m_awvalid && m_awready) hs++;
        end
        chk("t4_queued", 128'(hs), 128'(8));
        chk("t4_stalled", 128'(m_awvalid), 128'(0));
        m_wready = 1'b1;
        #1;
        chk("t4_pop_beat", 128'(m_wvalid), 128'(1));
        step();
        m_wready = 1'b0;
        chk("t4_no_grant_yet", 128'(m_awvalid), 128'(0));
        step();
        chk("t4_ninth_grant", 128'(m_awvalid), 128'(1));
        s_awvalid = '0;
        step();

        // Out-of-range B index is sunk and flagged.
        do_reset();
        m_bid = {3'd5, 4'hA}; m_bvalid = 1'b1;
        #1;
        chk("t5_sink_ready", 128'(m_bready), 128'(1));
        chk("t5_no_bvalid", 128'(s_bvalid), 128'(0));
        step();
        m_bvalid = 1'b0;
        chk("t5_bad_pulse", 128'(bad_bid), 128'(1));
        step();
        chk("t5_bad_clear", 128'(bad_bid), 128'(0));
        m_bid = {3'd4, 4'h6}; m_bvalid = 1'b1; s_bready = 5'b01111;
        #1;
        chk("t5_m4_bvalid", 128'(s_bvalid), 128'(5'b10000));
        chk("t5_m4_bready", 128'(m_bready), 128'(0));
        step();
        m_bvalid = 1'b0;

        // QoS preference, then reset during a stalled HOLD.
        do_reset();
        m_awready = 1'b1;
        s_awpayload[0*AWP_W +: AWP_W] = 68'(2) << QOS_LSB;
        s_awpayload[3*AWP_W +: AWP_W] = 68'(9) << QOS_LSB;
        s_awid[0*ID_W +: ID_W] = 4'd1;
        s_awid[3*ID_W +: ID_W] = 4'd2;
        s_awvalid = 5'b01001;
        step();
        chk("t6_first", 128'(m_awid >> ID_W), 128'(QOS ? 3 : 0));
        step();
        m_awready = 1'b0;
        step();
        chk("t6_hold", 128'(m_awvalid), 128'(1));
        step();
        chk("t6_stall", 128'(m_awvalid), 128'(1));
        #2;
        areset = 1'b1;
        mreset();
        s_wvalid = '1; m_wready = 1'b1;
        #1;
        chk("t6_rst_awvalid", 128'(m_awvalid), 128'(0));
        chk("t6_rst_wvalid", 128'(m_wvalid), 128'(0));
        chk("t6_rst_wready", 128'(s_wready), 128'(0));
        step();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_awvalid = N'($urandom);
            for (int m = 0; m < N; m++) begin
                s_awid[m*ID_W +: ID_W] = ID_W'($urandom);
                s_awpayload[m*AWP_W +: AWP_W] = AWP_W'(rnd128());
                s_wpayload[m*WP_W +: WP_W] = WP_W'(rnd128());
            end
            s_wvalid = N'($urandom);
            s_wlast = N'($urandom & $urandom);
            m_awready = 1'($urandom);
            if ((i / 400) % 2 == 1) m_wready = $urandom_range(0, 9) == 0;
            else                    m_wready = $urandom_range(0, 3) != 0;
            m_bid = 7'($urandom);
            m_bresp = 2'($urandom);
            m_bvalid = 1'($urandom);
            s_bready = N'($urandom);
            if (i == 1500) begin
                #2;
                areset = 1'b1;
                mreset();
                step();
                areset = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
